// File: rtl/gs_pipeline_sequencer.sv
// Sequences NUM_STAGES pipeline stages one at a time, each guarded by a watchdog.
// Optional GS_PIPE_SEQ_PERF_EN adds run_cycles, the busy length of the last completed run.
module gs_pipeline_sequencer #(
    parameter int NUM_STAGES = 3,
    parameter int TIMEOUT    = 1048576,
    parameter int TO_W       = 21
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_stage,
    output logic [1:0]            cur_stage,
    output logic [1:0]            state_dbg
`ifdef GS_PIPE_SEQ_PERF_EN
    ,
    output logic [31:0]           run_cycles
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]      state;
    logic [1:0]      idx;
    logic [TO_W-1:0] wd;
    logic [3:0]      done_ext;
    logic            idx_done;
    logic            last_stage;
    logic            wd_expired;
    logic            start_ok;

    // Handshake: stage_en is a level held until the active stage pulses its own done bit;
    // done bits of inactive stages, and all bits during GAP/FAULT, are ignored.
    assign done_ext   = 4'(stage_done);
    assign idx_done   = done_ext[idx];
    assign last_stage = (idx == 2'(NUM_STAGES - 1));
    assign wd_expired = (wd == TO_W'(TIMEOUT - 1));
    assign start_ok   = start && !abort;
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= 2'd0;
            wd        <= '0;
            stage_en  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_stage <= 2'd0;
            cur_stage <= 2'd0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (start_ok) begin
                    state     <= S_RUN;
                    idx       <= 2'd0;
                    wd        <= '0;
                    stage_en  <= NUM_STAGES'(1);
                    busy      <= 1'b1;
                    error     <= 1'b0;
                    err_stage <= 2'd0;
                    cur_stage <= 2'd0;
                end
            end else if (abort) begin
                // Abort beats any done or timeout in the same cycle and keeps the error flag.
                state     <= S_IDLE;
                idx       <= 2'd0;
                wd        <= '0;
                stage_en  <= '0;
                busy      <= 1'b0;
                cur_stage <= 2'd0;
            end else begin
                case (state)
                    S_RUN: begin
                        if (idx_done) begin
                            state    <= S_GAP;
                            stage_en <= '0;
                        end else if (wd_expired) begin
                            state     <= S_FAULT;
                            stage_en  <= '0;
                            error     <= 1'b1;
                            err_stage <= idx;
                        end else begin
                            wd <= wd + 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (!last_stage) begin
                            state     <= S_RUN;
                            idx       <= idx + 2'd1;
                            cur_stage <= idx + 2'd1;
                            stage_en  <= NUM_STAGES'(1) << (idx + 2'd1);
                            wd        <= '0;
                        end else begin
                            state     <= S_IDLE;
                            idx       <= 2'd0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cur_stage <= 2'd0;
                        end
                    end
                    S_FAULT: begin
                        state     <= S_IDLE;
                        idx       <= 2'd0;
                        busy      <= 1'b0;
                        cur_stage <= 2'd0;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef GS_PIPE_SEQ_PERF_EN
    logic [31:0] cyc_cnt;
    logic [31:0] cyc_next;

    assign cyc_next = (&cyc_cnt) ? cyc_cnt : cyc_cnt + 32'd1;

    // cyc_next at the final GAP edge already includes that last busy cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt    <= '0;
            run_cycles <= '0;
        end else if (state == S_IDLE) begin
            if (start_ok) begin
                cyc_cnt <= '0;
            end
        end else begin
            cyc_cnt <= cyc_next;
            if (state == S_GAP && last_stage && !abort) begin
                run_cycles <= cyc_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gs_pipeline_sequencer.sv
// Bench for gs_pipeline_sequencer: per-run expected timelines built from stage done times,
// directed scenarios followed by randomized runs with noise on ignored inputs.
module tb_gs_pipeline_sequencer;

    localparam int NS = 3;
    localparam int TO = 16;
    localparam int EW = NS + 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NS-1:0] stage_done = '0;
    logic [NS-1:0] stage_en;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    err_stage;
    logic [1:0]    cur_stage;
    logic [1:0]    state_dbg;
`ifdef GS_PIPE_SEQ_PERF_EN
    logic [31:0]   run_cycles;
`endif

    int checks = 0;
    int errors = 0;

    // Expected output per cycle: {stage_en, busy, done, error, err_stage, cur_stage}
    logic [EW-1:0] exp_q[$];
    // Input per cycle: {start, abort, stage_done}
    logic [NS+1:0] drv_q[$];
    logic          m_err = 1'b0;
    logic [1:0]    m_es  = 2'd0;
    logic [31:0]   m_rc  = 32'd0;

    gs_pipeline_sequencer #(
        .NUM_STAGES(NS),
        .TIMEOUT   (TO),
        .TO_W      (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .stage_done(stage_done),
        .stage_en  (stage_en),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_stage (err_stage),
        .cur_stage (cur_stage),
        .state_dbg (state_dbg)
`ifdef GS_PIPE_SEQ_PERF_EN
        ,
        .run_cycles(run_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] pk(input logic [NS-1:0] en, input logic b, input logic d,
                                         input logic e, input logic [1:0] es, input logic [1:0] cur);
        return {en, b, d, e, es, cur};
    endfunction

    function automatic logic [EW-1:0] observed();
        return {stage_en, busy, done, error, err_stage, cur_stage};
    endfunction

    task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_rc(input string tag);
`ifdef GS_PIPE_SEQ_PERF_EN
        checks++;
        assert (run_cycles === m_rc) else begin
            errors++;
            $error("FAIL %s run_cycles observed=%0d expected=%0d", tag, run_cycles, m_rc);
        end
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    // Stage i raises its done bit in its d[i]-th enable cycle; d[i] outside 1..TO means never.
    // abort_at: -1 none, 0 random busy cycle, >0 that cycle index.
    task automatic build(input int d[NS], input bit noise, input int abort_at);
        int            busy_n;
        int            ab;
        bit            completed;
        logic [NS-1:0] rnd;
        logic [NS+1:0] dv;
        logic [EW-1:0] e;
        exp_q.delete();
        drv_q.delete();
        exp_q.push_back(pk('0, 1'b0, 1'b0, m_err, m_es, 2'd0));
        drv_q.push_back({1'b1, 1'b0, noise ? NS'($urandom) : NS'(0)});
        completed = 1'b1;
        busy_n = 0;
        for (int i = 0; i < NS && completed; i++) begin
            for (int k = 1; k <= TO; k++) begin
                rnd = noise ? NS'($urandom) : NS'(0);
                rnd[i] = (k == d[i]);
                exp_q.push_back(pk(NS'(1) << i, 1'b1, 1'b0, 1'b0, 2'd0, 2'(i)));
                drv_q.push_back({noise && ($urandom_range(0, 7) == 0), 1'b0, rnd});
                busy_n++;
                if (k == d[i]) break;
            end
            if (d[i] >= 1 && d[i] <= TO) begin
                exp_q.push_back(pk('0, 1'b1, 1'b0, 1'b0, 2'd0, 2'(i)));
            end else begin
                exp_q.push_back(pk('0, 1'b1, 1'b0, 1'b1, 2'(i), 2'(i)));
                completed = 1'b0;
            end
            drv_q.push_back({noise && ($urandom_range(0, 3) == 0), 1'b0,
                             noise ? NS'($urandom) : NS'(0)});
            busy_n++;
        end
        e = exp_q[exp_q.size() - 1];
        exp_q.push_back(pk('0, 1'b0, completed, e[4], e[3:2], 2'd0));
        exp_q.push_back(pk('0, 1'b0, 1'b0, e[4], e[3:2], 2'd0));
        drv_q.push_back({1'b0, 1'b0, noise ? NS'($urandom) : NS'(0)});
        drv_q.push_back({(NS + 2){1'b0}});
        ab = (abort_at == 0) ? $urandom_range(1, busy_n) : abort_at;
        if (ab > 0) begin
            while (exp_q.size() > ab + 1) void'(exp_q.pop_back());
            while (drv_q.size() > ab + 1) void'(drv_q.pop_back());
            dv = drv_q[ab];
            dv[NS] = 1'b1;
            drv_q[ab] = dv;
            e = exp_q[ab];
            exp_q.push_back(pk('0, 1'b0, 1'b0, e[4], e[3:2], 2'd0));
            exp_q.push_back(pk('0, 1'b0, 1'b0, e[4], e[3:2], 2'd0));
            drv_q.push_back({(NS + 2){1'b0}});
            drv_q.push_back({(NS + 2){1'b0}});
        end else if (completed) begin
            m_rc = 32'(busy_n);
        end
        e = exp_q[exp_q.size() - 1];
        m_err = e[4];
        m_es  = e[3:2];
    endtask

    // Fixed-length replay: check outputs at negedge, then drive that cycle's inputs.
    task automatic run(input string tag, input int n_iter);
        int n;
        n = (n_iter < 0) ? exp_q.size() : n_iter;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s[%0d]", tag, i), observed(), exp_q[i]);
            {start, abort, stage_done} = drv_q[i];
        end
    endtask

    initial begin
        int d[NS];

        #12;
        check("reset_outputs", observed(), '0);
        check_rc("reset_rc");
        @(negedge clk);
        rst_n = 1'b1;

        build('{5, 5, 5}, 1'b0, -1);
        run("normal", -1);
        check_rc("normal_rc");

        build('{5, 5, 5}, 1'b1, -1);
        run("ignored_inputs", -1);
        check_rc("ignored_rc");

        build('{5, 0, 5}, 1'b0, -1);
        run("timeout", -1);
        build('{5, 5, 5}, 1'b0, -1);
        run("restart_clears_error", -1);

        build('{5, 5, 5}, 1'b0, 15);
        run("abort_stage2", -1);
        check_rc("abort_rc");

        build('{16, 3, 3}, 1'b0, -1);
        run("race_timeout_done", -1);
        check_rc("race_rc");

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        check("start_abort_idle", observed(), pk('0, 1'b0, 1'b0, m_err, m_es, 2'd0));
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle_hold", observed(), pk('0, 1'b0, 1'b0, m_err, m_es, 2'd0));

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < NS; i++) d[i] = $urandom_range(1, TO + 2);
            build(d, 1'b1, ($urandom_range(0, 3) == 0) ? 0 : -1);
            run($sformatf("rnd%0d", r), -1);
            check_rc("rnd_rc");
        end

        build('{5, 8, 5}, 1'b0, -1);
        run("pre_reset", 10);
        #2;
        rst_n = 1'b0;
        #1;
        m_err = 1'b0;
        m_es  = 2'd0;
        m_rc  = 32'd0;
        check("async_reset", observed(), '0);
        check_rc("async_reset_rc");
        @(negedge clk);
        {start, abort, stage_done} = '0;
        rst_n = 1'b1;
        build('{5, 5, 5}, 1'b0, -1);
        run("after_reset", -1);
        check_rc("after_reset_rc");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
